// File: rtl/fsm_rr_arbiter_if.sv
// Handshake bundle between requesters and the round-robin arbiter that owns the shared FSM input.
interface fsm_rr_arbiter_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned OW = $clog2(N);

  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  grant;
  logic [OW-1:0] owner;
  logic          busy;
  logic          timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  owner,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output owner,
    output busy,
    output timeout
  );
endinterface

// File: rtl/fsm_rr_arbiter.sv
// Round-robin arbiter granting exclusive use of a shared serial-input FSM to one of N requesters.
// Optional hold-time limit with forced release is enabled by defining ARB_TIMEOUT_EN.
module fsm_rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  fsm_rr_arbiter_if.slave  arb
);

  localparam int unsigned OW = $clog2(N);

  if (N < 2 || N > 8 || MAX_HOLD < 2) begin : g_bad_param
    $error("fsm_rr_arbiter: N must be 2..8 and MAX_HOLD >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q,   ptr_d;
  logic          busy_q,  busy_d;
  logic          timeout_q, timeout_d;

  logic          pick_vld_c;
  logic [OW-1:0] pick_c;
  logic          tmo_hit_c;
  logic          norm_rel_c;
  logic          release_c;
  logic          forced_c;

  // First pending requester at or after the round-robin pointer, wrapping modulo N.
  always_comb begin
    int unsigned idx;
    pick_vld_c = 1'b0;
    pick_c     = '0;
    idx        = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!pick_vld_c && arb.req[OW'(idx)]) begin
        pick_vld_c = 1'b1;
        pick_c     = OW'(idx);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD) + 1;

  logic [HW-1:0] hold_q, hold_d;

  assign tmo_hit_c = (hold_q == HW'(MAX_HOLD - 1));

  // Cycles spent in GRANT; cleared on entry so the grant stays up exactly MAX_HOLD cycles.
  always_comb begin
    hold_d = '0;
    if (state_q == S_GRANT && !release_c) begin
      hold_d = (hold_q == '1) ? hold_q : hold_q + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign tmo_hit_c = 1'b0;
`endif

  assign norm_rel_c = arb.done || !arb.req[owner_q];
  assign release_c  = norm_rel_c || tmo_hit_c;
  // A limit hit that coincides with a normal release is reported as a normal release.
  assign forced_c   = tmo_hit_c && !norm_rel_c;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld_c) begin
          state_d = S_GRANT;
          grant_d = N'(1) << pick_c;
          owner_d = pick_c;
          busy_d  = 1'b1;
        end
      end

      S_GRANT: begin
        if (release_c) begin
          state_d   = S_GAP;
          grant_d   = '0;
          busy_d    = 1'b0;
          ptr_d     = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);
          timeout_d = forced_c;
        end
      end

      S_GAP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign arb.grant   = grant_q;
  assign arb.owner   = owner_q;
  assign arb.busy    = busy_q;
  assign arb.timeout = timeout_q;

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Self-checking bench for fsm_rr_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_fsm_rr_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned MAX_HOLD = 16;
  localparam int unsigned OW       = $clog2(N);

  logic clk = 1'b0;
  logic reset;

  fsm_rr_arbiter_if #(.N(N)) arb ();

  fsm_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (arb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the FSM, how long the grant has been visible, and whose turn is next.
  bit m_busy = 1'b0;
  bit m_gap  = 1'b0;
  bit m_tmo  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_shown = 0;
  bit tmo_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  task automatic model_step();
    bit norm_rel;
    bit lim_rel;
    if (reset) begin
      m_busy = 0; m_gap = 0; m_tmo = 0; m_owner = 0; m_ptr = 0; m_shown = 0;
      return;
    end
    m_tmo = 0;
    if (m_busy) begin
      norm_rel = arb.done || !arb.req[OW'(m_owner)];
      lim_rel  = tmo_en && (m_shown == MAX_HOLD);
      if (norm_rel || lim_rel) begin
        m_busy = 0;
        m_gap  = 1;
        m_tmo  = lim_rel && !norm_rel;
        m_ptr  = (m_owner + 1) % N;
      end else begin
        m_shown++;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (arb.req != '0) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (arb.req[OW'((m_ptr + k) % N)]) m_owner = (m_ptr + k) % N;
      end
      m_busy  = 1;
      m_shown = 1;
    end
  endtask

  task automatic check_model();
    logic [N-1:0] exp_grant;
    exp_grant = m_busy ? (N'(1) << m_owner) : '0;
    check("grant",   32'(arb.grant),   32'(exp_grant));
    check("owner",   32'(arb.owner),   32'(m_owner));
    check("busy",    32'(arb.busy),    32'(m_busy));
    check("timeout", 32'(arb.timeout), 32'(m_tmo));
    check("onehot0", 32'($onehot0(arb.grant)), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic wait_busy(input string tag);
    int w;
    w = 0;
    while (!arb.busy && w < 12) begin
      tick();
      w++;
    end
    check(tag, 32'(arb.busy), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [N-1:0] exp_order [5];
  int cnt;

  initial begin
`ifdef ARB_TIMEOUT_EN
    tmo_en = 1'b1;
`else
    tmo_en = 1'b0;
`endif
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    reset    = 1'b1;
    arb.req  = '0;
    arb.done = 1'b0;

    // Reset held with requests pending.
    arb.req = 4'b1010;
    tick();
    check("t1_grant", 32'(arb.grant), 32'd0);
    tick();
    check("t1_owner", 32'(arb.owner), 32'd0);
    check("t1_busy",  32'(arb.busy),  32'd0);

    // Single request, one-cycle latency, release on done.
    reset   = 1'b0;
    arb.req = 4'b0100;
    tick();
    check("t2_grant", 32'(arb.grant), 32'b0100);
    check("t2_owner", 32'(arb.owner), 32'd2);
    arb.done = 1'b1;
    tick();
    check("t2_rel", 32'(arb.grant), 32'd0);
    arb.done = 1'b0;
    arb.req  = '0;
    tick();
    tick();

    // All requesting: rotation with wrap.
    do_reset();
    arb.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_busy("t3_wait");
      check("t3_order", 32'(arb.grant), 32'(exp_order[g]));
      arb.done = 1'b1;
      tick();
      arb.done = 1'b0;
    end

    // Held request with no done: forced release (or none).
    do_reset();
    arb.req = 4'b0001;
    wait_busy("t4_wait");
    cnt = 1;
    while (arb.busy && cnt < 40) begin
      tick();
      if (arb.busy) cnt++;
    end
`ifdef ARB_TIMEOUT_EN
    check("t4_len", 32'(cnt), 32'(MAX_HOLD));
    check("t4_tmo", 32'(arb.timeout), 32'd1);
    tick();
    check("t4_tmo_pulse", 32'(arb.timeout), 32'd0);
    tick();
    check("t4_regrant", 32'(arb.grant), 32'b0001);
`else
    check("t4_hold", 32'(arb.busy), 32'd1);
    check("t4_notmo", 32'(arb.timeout), 32'd0);
`endif
    arb.req = '0;
    tick(); tick(); tick();

    // Reset during an active grant.
    do_reset();
    arb.req = 4'b0010;
    wait_busy("t5_wait");
    check("t5_owner1", 32'(arb.owner), 32'd1);
    reset = 1'b1;
    tick();
    check("t5_rst_grant", 32'(arb.grant), 32'd0);
    check("t5_rst_owner", 32'(arb.owner), 32'd0);
    reset = 1'b0;
    tick();
    check("t5_regrant", 32'(arb.grant), 32'b0010);

    // Owner 3 drops its request; pointer wraps to 0.
    do_reset();
    arb.req = 4'b1000;
    wait_busy("t6_wait");
    check("t6_owner3", 32'(arb.owner), 32'd3);
    arb.req = 4'b0001;
    tick();
    check("t6_rel", 32'(arb.grant), 32'd0);
    tick();
    tick();
    check("t6_wrap", 32'(arb.grant), 32'b0001);

    // Randomized traffic with alternating busy/quiet phases.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit quiet;
      quiet = ((c / 150) % 2) == 1;
      reset = ($urandom_range(0, 249) == 0);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, quiet ? 39 : 4) == 0) arb.req[b] = ~arb.req[b];
      end
      arb.done = quiet ? 1'b0 : ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
